// File: rtl/storage_sequencer_pkg.sv
// storage_sequencer_pkg: shared widths, ring size, FSM states and phase encoding for the scan sequencer.
package storage_sequencer_pkg;
    localparam int PTS_W = 11;
    localparam int SLOT_W = 4;
    localparam int ADDR_W = 15;
    localparam int NUM_SLOTS = 10;
    typedef enum logic [2:0] {IDLE, ACQ, DIV, RATIO, DONE} phase_t;
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ACQ = 2'd1;
    localparam logic [1:0] PH_DIV = 2'd2;
    localparam logic [1:0] PH_RATIO = 2'd3;
    // DONE is a one-cycle wrap-up state and reports as IDLE on the phase port
    function automatic logic [1:0] phase_code(input phase_t s);
        return s == ACQ ? PH_ACQ : s == DIV ? PH_DIV : s == RATIO ? PH_RATIO : PH_IDLE;
    endfunction
endpackage

// File: rtl/storage_sequencer_if.sv
// storage_sequencer_if: front-end, divider, ratio-engine and RAM-side signals of the scan sequencer.
interface storage_sequencer_if;
    import storage_sequencer_pkg::*;
    logic start;
    logic abort;
    logic [PTS_W-1:0] points;
    logic sample_valid;
    logic div_valid;
    logic ratio_ready;
    logic busy;
    logic done;
    logic err_points;
    logic [1:0] phase;
    logic [PTS_W-1:0] cnt_point;
    logic [SLOT_W-1:0] cnt_save;
    logic [SLOT_W-1:0] slots_filled;
    logic div_enable;
    logic [PTS_W-1:0] cnt_div;
    logic ratio_enable;
    logic [PTS_W-1:0] cnt_ratio;
    logic wren;
    logic [ADDR_W-1:0] wr_address;
    logic [ADDR_W-1:0] rd_address;
    logic rd_valid;
    modport master (
        output start, abort, points, sample_valid, div_valid, ratio_ready,
        input busy, done, err_points, phase, cnt_point, cnt_save, slots_filled,
        input div_enable, cnt_div, ratio_enable, cnt_ratio, wren, wr_address, rd_address, rd_valid
    );
    modport slave (
        input start, abort, points, sample_valid, div_valid, ratio_ready,
        output busy, done, err_points, phase, cnt_point, cnt_save, slots_filled,
        output div_enable, cnt_div, ratio_enable, cnt_ratio, wren, wr_address, rd_address, rd_valid
    );
endinterface

// File: rtl/storage_sequencer_slot_addr_gen.sv
// slot_addr_gen: ring slot index, running slot bases and the RAM write/read address adders.
module slot_addr_gen import storage_sequencer_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic [PTS_W-1:0]  points,
    input  logic [PTS_W-1:0]  cnt_div,
    input  logic [PTS_W-1:0]  cnt_ratio,
    output logic [SLOT_W-1:0] cnt_save,
    output logic [SLOT_W-1:0] slots_filled,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr
);
    logic [ADDR_W-1:0] slot_base, prev_base;
    logic wrap;
    assign wrap = cnt_save == SLOT_W'(NUM_SLOTS - 1);
    assign wr_addr = slot_base + ADDR_W'(cnt_div);
    assign rd_addr = prev_base + ADDR_W'(cnt_ratio);
    // base = cnt_save*points kept by accumulation, reset to 0 on ring wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_save <= '0;
            slots_filled <= '0;
            slot_base <= '0;
            prev_base <= '0;
        end else if (advance) begin
            prev_base <= slot_base;
            cnt_save <= wrap ? '0 : cnt_save + SLOT_W'(1);
            slot_base <= wrap ? '0 : slot_base + ADDR_W'(points);
            slots_filled <= slots_filled == SLOT_W'(NUM_SLOTS) ? slots_filled : slots_filled + SLOT_W'(1);
        end
    end
endmodule

// File: rtl/storage_sequencer.sv
// storage_sequencer: scan FSM (acquire -> divide/store -> ratio), point counters and RAM strobes.
module storage_sequencer import storage_sequencer_pkg::*; (
    input logic clk,
    input logic rst,
    storage_sequencer_if.slave bus
);
    phase_t state, state_n;
    logic [PTS_W-1:0] points_q, cnt_point, cnt_div, cnt_ratio, last;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic kill, start_go, samp_go, wr_go, rd_go, advance, rd_issue;
    assign last = points_q - PTS_W'(1);
    assign kill = bus.abort && state != IDLE;
    assign start_go = state == IDLE && bus.start && !bus.abort && bus.points != '0;
    assign samp_go = state == ACQ && bus.sample_valid && !bus.abort;
    assign wr_go = state == DIV && bus.div_valid && !bus.abort;
    assign rd_go = state == RATIO && bus.ratio_ready && !bus.abort;
    assign advance = state == DONE && !bus.abort;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = kill ? IDLE
                : start_go ? ACQ
                : samp_go && cnt_point == last ? DIV
                : wr_go && cnt_div == last ? (bus.slots_filled != '0 ? RATIO : DONE)
                : rd_go && cnt_ratio == last ? DONE
                : state == DONE ? IDLE
                : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            points_q <= '0;
            cnt_point <= '0;
            cnt_div <= '0;
            cnt_ratio <= '0;
            bus.wren <= 1'b0;
            bus.wr_address <= '0;
            bus.rd_address <= '0;
            rd_issue <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.err_points <= 1'b0;
        end else begin
            bus.err_points <= state == IDLE && bus.start && !bus.abort && bus.points == '0;
            if (start_go) begin
                points_q <= bus.points;
                cnt_point <= '0;
                cnt_div <= '0;
                cnt_ratio <= '0;
            end
            if (samp_go) cnt_point <= cnt_point + PTS_W'(1);
            if (wr_go) cnt_div <= cnt_div + PTS_W'(1);
            if (rd_go) cnt_ratio <= cnt_ratio + PTS_W'(1);
            bus.wren <= wr_go;
            bus.wr_address <= wr_go ? wr_addr : '0;
            bus.rd_address <= rd_go ? rd_addr : '0;
            rd_issue <= rd_go;
            bus.rd_valid <= rd_issue && !kill;
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.phase = phase_code(state);
    assign bus.div_enable = state == DIV;
    assign bus.ratio_enable = state == RATIO;
    assign bus.cnt_point = cnt_point;
    assign bus.cnt_div = cnt_div;
    assign bus.cnt_ratio = cnt_ratio;
    slot_addr_gen u_slot (
        .clk(clk),
        .rst(rst),
        .advance(advance),
        .points(points_q),
        .cnt_div(cnt_div),
        .cnt_ratio(cnt_ratio),
        .cnt_save(bus.cnt_save),
        .slots_filled(bus.slots_filled),
        .wr_addr(wr_addr),
        .rd_addr(rd_addr)
    );
endmodule

// File: tb/tb_storage_sequencer.sv
// tb_storage_sequencer: directed scans against hand-computed counters, strobes and RAM addresses.
module tb_storage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    storage_sequencer_if bus();
    storage_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int p);
        bus.points = 11'(p);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_phase", 32'(bus.phase), 1);
    endtask

    task automatic do_acq(input int p);
        bus.sample_valid = 1'b1;
        for (int i = 0; i < p; i++) tick();
        bus.sample_valid = 1'b0;
        chk("acq_cnt_point", 32'(bus.cnt_point), 32'(p));
        chk("acq_to_div", 32'(bus.div_enable), 1);
    endtask

    task automatic do_div(input int p, input int wbase);
        bus.div_valid = 1'b1;
        for (int i = 0; i < p; i++) begin
            tick();
            chk("div_wren", 32'(bus.wren), 1);
            chk("div_wr_address", 32'(bus.wr_address), 32'(wbase + i));
        end
        bus.div_valid = 1'b0;
    endtask

    task automatic do_ratio(input int p, input int rbase);
        chk("ratio_enable", 32'(bus.ratio_enable), 1);
        bus.ratio_ready = 1'b1;
        for (int i = 0; i < p; i++) begin
            tick();
            chk("ratio_rd_address", 32'(bus.rd_address), 32'(rbase + i));
            chk("ratio_rd_valid", 32'(bus.rd_valid), i > 0 ? 1 : 0);
        end
        bus.ratio_ready = 1'b0;
        chk("ratio_done", 32'(bus.done), 1);
        tick();
        chk("ratio_last_rd_valid", 32'(bus.rd_valid), 1);
        chk("ratio_rd_address_idle", 32'(bus.rd_address), 0);
        chk("ratio_busy_low", 32'(bus.busy), 0);
        tick();
        chk("ratio_rd_valid_low", 32'(bus.rd_valid), 0);
    endtask

    task automatic run_scan(input int p, input int wbase, input bit with_ratio, input int rbase);
        do_start(p);
        do_acq(p);
        do_div(p, wbase);
        if (with_ratio) do_ratio(p, rbase);
        else begin
            chk("noratio_done", 32'(bus.done), 1);
            tick();
            chk("noratio_done_low", 32'(bus.done), 0);
            chk("noratio_busy_low", 32'(bus.busy), 0);
            chk("noratio_wren_low", 32'(bus.wren), 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.points = '0;
        bus.sample_valid = 1'b0;
        bus.div_valid = 1'b0;
        bus.ratio_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_wren", 32'(bus.wren), 0);
        chk("rst_cnt_save", 32'(bus.cnt_save), 0);
        chk("rst_slots_filled", 32'(bus.slots_filled), 0);
        chk("rst_done", 32'(bus.done), 0);
        // scan 1: slot 0, no previous slot to ratio against
        run_scan(4, 0, 1'b0, 0);
        chk("s1_cnt_save", 32'(bus.cnt_save), 1);
        chk("s1_slots_filled", 32'(bus.slots_filled), 1);
        // scan 2: slot 1 at base 4, reads slot 0
        run_scan(4, 4, 1'b1, 0);
        chk("s2_cnt_save", 32'(bus.cnt_save), 2);
        // scan 3: start during ACQ ignored, then abort after 2 writes to slot 2 (base 8)
        do_start(4);
        bus.sample_valid = 1'b1;
        tick();
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_in_acq_cnt", 32'(bus.cnt_point), 3);
        chk("start_in_acq_phase", 32'(bus.phase), 1);
        tick();
        bus.sample_valid = 1'b0;
        chk("acq_done_phase", 32'(bus.phase), 2);
        do_div(2, 8);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_phase", 32'(bus.phase), 0);
        chk("abort_wren", 32'(bus.wren), 0);
        chk("abort_div_enable", 32'(bus.div_enable), 0);
        chk("abort_done", 32'(bus.done), 0);
        tick();
        chk("abort_no_done_later", 32'(bus.done), 0);
        chk("abort_cnt_save", 32'(bus.cnt_save), 2);
        run_scan(4, 8, 1'b1, 4);
        chk("restart_cnt_save", 32'(bus.cnt_save), 3);
        // rejected start with zero points
        bus.points = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("zero_err_points", 32'(bus.err_points), 1);
        chk("zero_busy", 32'(bus.busy), 0);
        tick();
        chk("zero_err_pulse_end", 32'(bus.err_points), 0);
        // scan on slot 3 (base 12) with a ratio_ready gap, reading slot 2 (base 8)
        do_start(4);
        do_acq(4);
        do_div(4, 12);
        chk("gap_phase_ratio", 32'(bus.phase), 3);
        bus.ratio_ready = 1'b1;
        tick();
        chk("gap_rd0", 32'(bus.rd_address), 8);
        chk("gap_rv0", 32'(bus.rd_valid), 0);
        tick();
        chk("gap_rd1", 32'(bus.rd_address), 9);
        chk("gap_rv1", 32'(bus.rd_valid), 1);
        bus.ratio_ready = 1'b0;
        bus.div_valid = 1'b1;
        tick();
        chk("gap_rd_idle", 32'(bus.rd_address), 0);
        chk("gap_rv_trail", 32'(bus.rd_valid), 1);
        chk("gap_no_wren", 32'(bus.wren), 0);
        chk("gap_cnt_ratio", 32'(bus.cnt_ratio), 2);
        tick();
        chk("gap_rv_low", 32'(bus.rd_valid), 0);
        chk("gap_no_wren2", 32'(bus.wren), 0);
        tick();
        chk("gap_rd_idle2", 32'(bus.rd_address), 0);
        chk("gap_still_ratio", 32'(bus.phase), 3);
        bus.div_valid = 1'b0;
        bus.ratio_ready = 1'b1;
        tick();
        chk("gap_rd2", 32'(bus.rd_address), 10);
        chk("gap_cnt_ratio3", 32'(bus.cnt_ratio), 3);
        tick();
        chk("gap_rd3", 32'(bus.rd_address), 11);
        chk("gap_done", 32'(bus.done), 1);
        bus.ratio_ready = 1'b0;
        tick();
        chk("gap_last_rv", 32'(bus.rd_valid), 1);
        chk("gap_done_low", 32'(bus.done), 0);
        chk("gap_cnt_save", 32'(bus.cnt_save), 4);
        // full ring of 2047-point scans including the wrap back to slot 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_cnt_save", 32'(bus.cnt_save), 0);
        for (int k = 0; k < 11; k++)
            run_scan(2047, (k % 10) * 2047, k > 0, ((k + 9) % 10) * 2047);
        chk("ring_slots_filled", 32'(bus.slots_filled), 10);
        chk("ring_cnt_save", 32'(bus.cnt_save), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
